// File: rtl/mips_core_pkg.sv
// Shared types for the branch checkpoint controller: slot record, FSM states, default sizing.
package mips_core_pkg;
    localparam int CKPT_NUM   = 4;
    localparam int CKPT_IDX_W = $clog2(CKPT_NUM);
    localparam int CKPT_ID_W  = 20;

    typedef enum logic {CKPT_RUN, CKPT_RECOVER} ckpt_fsm_e;

    typedef struct packed {
        logic                 valid;
        logic                 resolved;
        logic [CKPT_ID_W-1:0] id;
    } ckpt_slot_t;
endpackage

// File: rtl/ckpt_cam_match.sv
// N-way equality compare of a resolve id against the live checkpoint ids; purely combinational.
module ckpt_cam_match #(
    parameter  int N     = 4,
    parameter  int ID_W  = 20,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [ID_W-1:0]  key,
    input  logic [N-1:0]     valid,
    input  logic [ID_W-1:0]  ids [N],
    output logic             hit,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = valid[i] && (ids[i] == key);
            if (onehot[i]) idx = IDX_W'(i);
        end
        hit = |onehot;
    end
endmodule

// File: rtl/branch_checkpoint_ctrl.sv
// Branch checkpoint allocator: circular slot FIFO, in-order retire, mispredict squash + restore pulse.
// Define BRANCH_CKPT_STATS_EN to add saturating grant / mispredict / full-stall counters.
module branch_checkpoint_ctrl
    import mips_core_pkg::*;
#(
    parameter  int NUM_CKPT = CKPT_NUM,
    parameter  int ID_WIDTH = CKPT_ID_W,
    localparam int IDX_W    = $clog2(NUM_CKPT),
    localparam int CNT_W    = IDX_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_req,
    input  logic [ID_WIDTH-1:0] alloc_id,
    output logic                alloc_gnt,
    output logic [IDX_W-1:0]    alloc_idx,
    output logic                full,
    input  logic                resolve_valid,
    input  logic [ID_WIDTH-1:0] resolve_id,
    input  logic                resolve_mispredict,
    output logic                restore_valid,
    output logic [IDX_W-1:0]    restore_idx,
    output logic [ID_WIDTH-1:0] flush_id,
    output logic                branch_pending,
    output logic [ID_WIDTH-1:0] oldest_pending_id
`ifdef BRANCH_CKPT_STATS_EN
    ,
    output logic [31:0]         stat_alloc,
    output logic [31:0]         stat_mispredict,
    output logic [31:0]         stat_full_stall
`endif
);
    ckpt_slot_t          slots    [NUM_CKPT];
    ckpt_slot_t          slot_nxt [NUM_CKPT];
    logic [ID_WIDTH-1:0] slot_ids [NUM_CKPT];
    logic [NUM_CKPT-1:0] slot_valid;
    logic [NUM_CKPT-1:0] hit_onehot;
    logic [IDX_W-1:0]    head, tail, head_nxt, tail_nxt, hit_idx, off_m, off_i;
    logic [CNT_W-1:0]    count, count_nxt;
    logic                cam_hit, in_run, mispredict_hit, correct_hit, head_retire;
    ckpt_fsm_e           state, state_nxt;

    always_comb begin
        for (int i = 0; i < NUM_CKPT; i++) begin
            slot_valid[i] = slots[i].valid;
            slot_ids[i]   = ID_WIDTH'(slots[i].id);
        end
    end

    ckpt_cam_match #(.N(NUM_CKPT), .ID_W(ID_WIDTH)) u_cam (
        .key    (resolve_id),
        .valid  (slot_valid),
        .ids    (slot_ids),
        .hit    (cam_hit),
        .onehot (hit_onehot),
        .idx    (hit_idx)
    );

    assign in_run         = (state == CKPT_RUN);
    assign mispredict_hit = in_run && resolve_valid && cam_hit && resolve_mispredict;
    assign correct_hit    = in_run && resolve_valid && cam_hit && !resolve_mispredict;
    assign alloc_gnt      = in_run && alloc_req && !full && !mispredict_hit;
    assign alloc_idx      = tail;
    // A squash that starts at head takes the head with it, so it must not also count as a retire.
    assign head_retire    = slots[head].valid && slots[head].resolved
                            && !(mispredict_hit && hit_idx == head);
    // Distance from head orders slots by age, independent of id values.
    assign off_m          = hit_idx - head;

    always_comb begin
        slot_nxt  = slots;
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count + CNT_W'(alloc_gnt) - CNT_W'(head_retire);
        off_i     = '0;
        if (correct_hit) slot_nxt[hit_idx].resolved = 1'b1;
        if (alloc_gnt) begin
            slot_nxt[tail] = '{valid: 1'b1, resolved: 1'b0, id: CKPT_ID_W'(alloc_id)};
            tail_nxt       = tail + IDX_W'(1);
        end
        if (head_retire) begin
            slot_nxt[head] = '0;
            head_nxt       = head + IDX_W'(1);
        end
        if (mispredict_hit) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                off_i = IDX_W'(i) - head;
                if (off_i >= off_m) slot_nxt[i] = '0;
            end
            tail_nxt  = hit_idx;
            count_nxt = CNT_W'(off_m) - CNT_W'(head_retire);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CKPT_RUN:     if (mispredict_hit) state_nxt = CKPT_RECOVER;
            CKPT_RECOVER: state_nxt = CKPT_RUN;
            default:      state_nxt = CKPT_RUN;
        endcase
    end

    always_comb begin
        branch_pending = 1'b0;
        for (int i = 0; i < NUM_CKPT; i++)
            branch_pending = branch_pending | (slots[i].valid & ~slots[i].resolved);
        oldest_pending_id = branch_pending ? ID_WIDTH'(slots[head].id) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CKPT; i++) slots[i] <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            full          <= 1'b0;
            state         <= CKPT_RUN;
            restore_valid <= 1'b0;
            restore_idx   <= '0;
            flush_id      <= '0;
        end else begin
            slots         <= slot_nxt;
            head          <= head_nxt;
            tail          <= tail_nxt;
            count         <= count_nxt;
            full          <= (count_nxt == CNT_W'(NUM_CKPT));
            state         <= state_nxt;
            restore_valid <= mispredict_hit;
            if (mispredict_hit) begin
                restore_idx <= hit_idx;
                flush_id    <= resolve_id;
            end
        end
    end

`ifdef BRANCH_CKPT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_alloc      <= '0;
            stat_mispredict <= '0;
            stat_full_stall <= '0;
        end else begin
            if (alloc_gnt && stat_alloc != '1)             stat_alloc      <= stat_alloc + 32'd1;
            if (mispredict_hit && stat_mispredict != '1)   stat_mispredict <= stat_mispredict + 32'd1;
            if (alloc_req && full && stat_full_stall != '1) stat_full_stall <= stat_full_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_checkpoint_ctrl.sv
// Directed bench for branch_checkpoint_ctrl: allocation, in-order retire, mispredict recovery, wrap.
module tb_branch_checkpoint_ctrl;
    localparam int N   = 4;
    localparam int IDW = 20;

    logic           clk = 1'b0;
    logic           rst;
    logic           alloc_req;
    logic [IDW-1:0] alloc_id;
    logic           alloc_gnt;
    logic [1:0]     alloc_idx;
    logic           full;
    logic           resolve_valid;
    logic [IDW-1:0] resolve_id;
    logic           resolve_mispredict;
    logic           restore_valid;
    logic [1:0]     restore_idx;
    logic [IDW-1:0] flush_id;
    logic           branch_pending;
    logic [IDW-1:0] oldest_pending_id;
`ifdef BRANCH_CKPT_STATS_EN
    logic [31:0]    stat_alloc, stat_mispredict, stat_full_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    branch_checkpoint_ctrl #(.NUM_CKPT(N), .ID_WIDTH(IDW)) dut (
        .clk                (clk),
        .rst                (rst),
        .alloc_req          (alloc_req),
        .alloc_id           (alloc_id),
        .alloc_gnt          (alloc_gnt),
        .alloc_idx          (alloc_idx),
        .full               (full),
        .resolve_valid      (resolve_valid),
        .resolve_id         (resolve_id),
        .resolve_mispredict (resolve_mispredict),
        .restore_valid      (restore_valid),
        .restore_idx        (restore_idx),
        .flush_id           (flush_id),
        .branch_pending     (branch_pending),
        .oldest_pending_id  (oldest_pending_id)
`ifdef BRANCH_CKPT_STATS_EN
        ,
        .stat_alloc         (stat_alloc),
        .stat_mispredict    (stat_mispredict),
        .stat_full_stall    (stat_full_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; comb outputs are sampled 1ns later.
    task automatic drive(input logic a_req, input int a_id, input logic r_v, input int r_id,
                         input logic r_mis);
        @(negedge clk);
        alloc_req          = a_req;
        alloc_id           = IDW'(a_id);
        resolve_valid      = r_v;
        resolve_id         = IDW'(r_id);
        resolve_mispredict = r_mis;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        alloc_req = 1'b0; alloc_id = '0;
        resolve_valid = 1'b0; resolve_id = '0; resolve_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_full", full, 0);
        chk("rst_restore_valid", restore_valid, 0);
        chk("rst_restore_idx", restore_idx, 0);
        chk("rst_flush_id", flush_id, 0);
        chk("rst_pending", branch_pending, 0);
        chk("rst_oldest", oldest_pending_id, 0);
        @(negedge clk) rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            drive(1, 10 + k, 0, 0, 0);
            chk("fill_gnt", alloc_gnt, 1);
            chk("fill_idx", alloc_idx, k);
            tick();
        end
        chk("full_after_4", full, 1);
        chk("oldest_10", oldest_pending_id, 10);
        chk("pending_fill", branch_pending, 1);
        drive(1, 14, 0, 0, 0);
        chk("gnt_when_full", alloc_gnt, 0);
        tick();
        chk("still_full", full, 1);

        drive(0, 0, 1, 10, 0);
        tick();
        chk("correct_no_restore", restore_valid, 0);
        drive(0, 0, 1, 11, 0);
        tick();
        chk("full_cleared", full, 0);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("oldest_12", oldest_pending_id, 12);
        chk("count_2", dut.count, 2);

        drive(0, 0, 1, 12, 0);
        tick();
        drive(0, 0, 1, 13, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk("drained_pending", branch_pending, 0);
        chk("drained_oldest", oldest_pending_id, 0);

        for (int k = 0; k < 3; k++) begin
            drive(1, 20 + k, 0, 0, 0);
            chk("alloc2x_gnt", alloc_gnt, 1);
            chk("alloc2x_idx", alloc_idx, k);
            tick();
        end
        drive(0, 0, 1, 21, 1);
        tick();
        chk("mp21_restore_valid", restore_valid, 1);
        chk("mp21_restore_idx", restore_idx, 1);
        chk("mp21_flush_id", flush_id, 21);
        chk("mp21_tail", dut.tail, 1);
        chk("mp21_count", dut.count, 1);
        drive(1, 23, 0, 0, 0);
        chk("recover_no_gnt", alloc_gnt, 0);
        tick();
        chk("restore_pulse_end", restore_valid, 0);
        drive(1, 23, 0, 0, 0);
        chk("post_recover_gnt", alloc_gnt, 1);
        chk("post_recover_idx", alloc_idx, 1);
        tick();

        drive(1, 30, 1, 20, 1);
        chk("alloc_vs_mp_gnt", alloc_gnt, 0);
        tick();
        chk("mp_head_count", dut.count, 0);
        chk("mp_head_restore_idx", restore_idx, 0);
        chk("mp_head_flush_id", flush_id, 20);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("mp_head_pending", branch_pending, 0);
        chk("mp_head_oldest", oldest_pending_id, 0);

        drive(1, 40, 0, 0, 0);
        chk("alloc40_idx", alloc_idx, 0);
        tick();
        drive(0, 0, 1, 99, 1);
        tick();
        chk("unknown_no_restore", restore_valid, 0);
        chk("unknown_count", dut.count, 1);
        chk("unknown_oldest", oldest_pending_id, 40);
        chk("unknown_flush_hold", flush_id, 20);
        drive(0, 0, 1, 40, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk("drain40_count", dut.count, 0);

        for (int k = 0; k < 10; k++) begin
            drive(1, 50 + k, 0, 0, 0);
            chk("wrap_gnt", alloc_gnt, 1);
            chk("wrap_idx", alloc_idx, (1 + k) % 4);
            tick();
            chk("wrap_no_full", full, 0);
            drive(0, 0, 1, 50 + k, 0);
            tick();
            drive(0, 0, 0, 0, 0);
            tick();
        end
        chk("wrap_head", dut.head, 3);
        chk("wrap_tail", dut.tail, 3);
        chk("wrap_count", dut.count, 0);

        drive(1, 60, 0, 0, 0);
        tick();
        drive(0, 0, 1, 60, 1);
        tick();
        chk("pre_rst_restore", restore_valid, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_restore", restore_valid, 0);
        @(negedge clk) rst = 1'b0;
        drive(1, 61, 0, 0, 0);
        chk("after_rst_gnt", alloc_gnt, 1);
        chk("after_rst_idx", alloc_idx, 0);
        tick();
        drive(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
